// File: rtl/reg_b.sv
// reg_b: 4-bit general-purpose register B of the microcode processor.
// Each clock the register loads from the immediate field or from the shared
// tri-state bus, and it drives its contents back onto the bus when asked.
// Optional feature macro: REG_B_ZFLAG_EN adds the combinational zero flag zf.
module reg_b (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] im,
  input  logic       rs3,
  input  logic       rs4,
  input  logic       ws2,
  inout  wire  [3:0] bus
`ifdef REG_B_ZFLAG_EN
  ,
  output logic       zf
`endif
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next-state select: immediate beats bus; a bus load while driving is a self-load and holds.
  always_comb begin
    q_d = q_q;
    if (rs3) begin
      q_d = im;
    end else if (rs4 && !ws2) begin
      q_d = bus;
    end else begin
      q_d = q_q;
    end
  end

  // State register with synchronous active-high reset overriding any load.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 4'b0000;
    end else begin
      q_q <= q_d;
    end
  end

  // Bus drive is purely combinational from ws2 and the register, reset included.
  assign bus = ws2 ? q_q : 4'bzzzz;

`ifdef REG_B_ZFLAG_EN
  // Zero flag follows the register contents directly.
  always_comb begin
    if (q_q == 4'b0000) begin
      zf = 1'b1;
    end else begin
      zf = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_reg_b.sv
// Self-checking bench for reg_b: directed steps plus a short random phase,
// expected bus values flow through a scoreboard queue.
module tb_reg_b;

  logic       clk;
  logic       rst;
  logic [3:0] im;
  logic       rs3;
  logic       rs4;
  logic       ws2;
  wire  [3:0] bus;
  logic       drv_en;
  logic [3:0] drv_val;
`ifdef REG_B_ZFLAG_EN
  logic       zf;
`endif

  typedef struct {
    string      tag;
    logic [3:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  logic [3:0] model_q;

  // External bus driver standing in for the rest of the processor.
  assign bus = drv_en ? drv_val : 4'bzzzz;

  reg_b dut (
    .clk (clk),
    .rst (rst),
    .im  (im),
    .rs3 (rs3),
    .rs4 (rs4),
    .ws2 (ws2),
    .bus (bus)
`ifdef REG_B_ZFLAG_EN
    ,
    .zf  (zf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [3:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_check_bus();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      checks++;
      assert (bus === e.val) else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b", e.tag, bus, e.val);
      end
    end
  endtask

  task automatic check_zf(input string tag, input logic expz);
`ifdef REG_B_ZFLAG_EN
    checks++;
    assert (zf === expz) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, zf, expz);
    end
`else
    if (tag.len() < 0 || expz === 1'bx) begin
      // zero flag not built in this configuration
    end
`endif
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0; im = 4'b0000; rs3 = 1'b0; rs4 = 1'b0; ws2 = 1'b0;
    drv_en = 1'b0; drv_val = 4'b0000;
    #2;

    // Reset with all selects low, then read back
    rst = 1'b1;
    step();
    rst = 1'b0;
    ws2 = 1'b1;
    push("reset_bus", 4'b0000);
    #1;
    pop_check_bus();
    check_zf("reset_zf", 1'b1);

    // Immediate load, then hold across idle edges
    ws2 = 1'b0; im = 4'b1001; rs3 = 1'b1;
    push("imm_load", 4'b1001);
    step();
    rs3 = 1'b0; im = 4'b0000; ws2 = 1'b1;
    #1;
    pop_check_bus();
    check_zf("imm_zf", 1'b0);
    push("imm_hold1", 4'b1001);
    step();
    pop_check_bus();
    push("imm_hold2", 4'b1001);
    step();
    pop_check_bus();

    // Release: with ws2 low only the external driver is seen
    ws2 = 1'b0; drv_en = 1'b1; drv_val = 4'b0110;
    push("release_ext_drive", 4'b0110);
    #1;
    pop_check_bus();

    // Bus load
    rs4 = 1'b1;
    push("bus_load", 4'b0110);
    step();
    rs4 = 1'b0; drv_en = 1'b0; ws2 = 1'b1;
    #1;
    pop_check_bus();
    check_zf("bus_load_zf", 1'b0);

    // rs3 wins over rs4
    ws2 = 1'b0; drv_en = 1'b1; drv_val = 4'b0110; im = 4'b1001;
    rs3 = 1'b1; rs4 = 1'b1;
    push("priority", 4'b1001);
    step();
    rs3 = 1'b0; rs4 = 1'b0; drv_en = 1'b0; ws2 = 1'b1;
    #1;
    pop_check_bus();

    // Self-load keeps the value across the edge
    rs4 = 1'b1;
    push("self_load_pre", 4'b1001);
    #1;
    pop_check_bus();
    push("self_load_post", 4'b1001);
    step();
    pop_check_bus();
    rs4 = 1'b0;

    // Loads with ws2 low leave the bus to the external driver
    ws2 = 1'b0; drv_en = 1'b1; drv_val = 4'b0011; im = 4'b0101; rs3 = 1'b1;
    push("quiet_load_pre", 4'b0011);
    #1;
    pop_check_bus();
    push("quiet_load_post", 4'b0011);
    step();
    pop_check_bus();
    rs3 = 1'b0; drv_en = 1'b0; ws2 = 1'b1;
    push("quiet_load_value", 4'b0101);
    #1;
    pop_check_bus();

    // Reset overrides a simultaneous load
    ws2 = 1'b0; im = 4'b1001; rs3 = 1'b1;
    step();
    rst = 1'b1; im = 4'b1111; rs3 = 1'b1;
    push("reset_mid_op", 4'b0000);
    step();
    rst = 1'b0; rs3 = 1'b0; ws2 = 1'b1;
    #1;
    pop_check_bus();
    check_zf("reset_mid_zf", 1'b1);

    // ws2 keeps driving while reset is asserted
    ws2 = 1'b0; im = 4'b1010; rs3 = 1'b1;
    step();
    rs3 = 1'b0; rst = 1'b1; ws2 = 1'b1;
    push("drive_in_reset_pre", 4'b1010);
    #1;
    pop_check_bus();
    push("drive_in_reset_post", 4'b0000);
    step();
    pop_check_bus();

    // Loads resume on the first edge with rst low
    rst = 1'b0; im = 4'b0111; rs3 = 1'b1;
    push("load_after_reset", 4'b0111);
    step();
    rs3 = 1'b0;
    pop_check_bus();

    // Random phase against a reference model
    model_q = 4'b0111;
    for (int i = 0; i < 40; i++) begin
      ws2 = 1'($urandom_range(0, 1));
      rs3 = 1'($urandom_range(0, 1));
      rs4 = 1'($urandom_range(0, 1));
      im  = 4'($urandom_range(0, 15));
      drv_val = 4'($urandom_range(0, 15));
      drv_en  = !ws2;
      #1;
      if (ws2) begin
        push("rand_drive", model_q);
      end else begin
        push("rand_ext", drv_val);
      end
      pop_check_bus();
      check_zf("rand_zf", model_q == 4'b0000);
      if (rs3) begin
        model_q = im;
      end else if (rs4 && !ws2) begin
        model_q = drv_val;
      end else begin
        model_q = model_q;
      end
      step();
    end
    drv_en = 1'b0; rs3 = 1'b0; rs4 = 1'b0; ws2 = 1'b1;
    push("rand_final", model_q);
    #1;
    pop_check_bus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_b.md
# reg_b

4-bit general-purpose register B of the simple hierarchical microcode processor's register file. Each clock it loads from the instruction immediate field or from the shared tri-state data bus, under microcode select lines, and drives its contents back onto the bus on request. It is a leaf block; the microcode sequencer owns all control lines and keeps bus access exclusive.

## Interface
- Parameters: none. Data width is fixed at 4 bits.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset. One clock; reset is synchronous and active-high. Clears the register.
- im  input  4  immediate operand from the instruction word.
- rs3  input  1  load register from `im`.
- rs4  input  1  load register from `bus`.
- ws2  input  1  drive register contents onto `bus`.
- bus  inout  4  shared processor data bus, tri-state.
- zf  output  1  zero flag. Present only when `REG_B_ZFLAG_EN` is defined.

## Operation
- Internal state: one 4-bit register `q`.
- Register update on each rising clk edge, with this priority:
  1. `rst`=1: `q` <= 4'b0000. All selects are ignored.
  2. `rs3`=1: `q` <= `im`.
  3. `rs4`=1 and `ws2`=0: `q` <= `bus`.
  4. Otherwise `q` holds its value.
- `rs3` takes priority over `rs4` when both are asserted.
- `rs4` with `ws2` asserted is a self-load. `q` stays unchanged and the bus value is not sampled.
- Bus drive is combinational: `bus` = `q` when `ws2`=1, else 4'bZZZZ on all bits.
- `ws2` alone controls the bus drive, including during reset.
- `rs3`/`rs4` never drive the bus. The block never reads `im` or `bus` except on a load edge.
- Bus contention, where `ws2` is asserted while another bus driver is active, is the sequencer's responsibility. The block performs no arbitration.
- No X-propagation masking. If `bus` is Z/X during an `rs4` load, `q` captures it as-is.

## Timing
- Load latency: one clock. A select and its data that are valid before edge N appear in `q` immediately after edge N.
- Bus output latency: combinational from `ws2` and `q`, with zero cycles.
- After a load with `ws2` held high, `bus` shows the new value right after the loading edge.
- Reset value: `q` = 0. `bus` = Z unless `ws2`=1, in which case it reads 4'b0000 after the reset edge. `zf` = 1 after reset.
- Reset mid-operation: a reset edge overrides any simultaneous load. Loads resume on the first edge with `rst`=0.
- Selects may change every cycle. Each edge acts independently on the selects sampled at that edge.

## Configuration
- `REG_B_ZFLAG_EN` defined:
  - adds output `zf` = 1 when `q` == 4'b0000, else 0;
  - `zf` is combinational from `q`, so it updates with a one-clock latency relative to loads.
- `REG_B_ZFLAG_EN` undefined: no `zf` port. All other behaviour is identical.

## Test plan
- Reset: `rst`=1 for one edge, all selects 0, then `ws2`=1 → `bus`=4'b0000; `zf`=1 if enabled.
- Immediate load: `im`=4'b1001, `rs3`=1 for one edge, then `rs3`=0, `ws2`=1 → `bus`=4'b1001, holds on later idle edges; `zf`=0.
- Bus load: external driver puts 4'b0110 on `bus`, `rs4`=1 for one edge, driver released, `ws2`=1 → `bus`=4'b0110.
- Priority and self-load:
  - `rs3`=1 and `rs4`=1 with `im`=4'b1001, `bus`=4'b0110 → `q`=4'b1001;
  - `rs4`=1 and `ws2`=1 → `bus` stays 4'b1001 across the edge.
- Tri-state release: `ws2` 1→0 with no other driver → `bus`=4'bZZZZ in the same delta. Loads with `ws2`=0 never disturb the bus.
- Reset mid-operation: `q`=4'b1001, `rst`=1 together with `rs3`=1 and `im`=4'b1111 → `q`=4'b0000 after the edge.
